// File: rtl/eth_rxcmd_scheduler.sv
// Receive-side command scheduler: filters decoded frame commands by MAC, commits them at a
// clean end-of-frame into a small FIFO and issues them one at a time over a req/ack port.
module eth_rxcmd_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          MRxClk,
    input  logic                          Reset,
    input  logic                          RxValid,
    input  logic [3:0]                    opcode,
    input  logic [23:0]                   address,
    input  logic [47:0]                   dst_mac_reg,
    input  logic [47:0]                   MAC,
    input  logic                          RxEndFrm,
    input  logic                          CrcError,
    output logic                          cmd_req,
    output logic [3:0]                    cmd_op,
    output logic [23:0]                   cmd_addr,
    input  logic                          cmd_ack,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   done_cnt,
    output logic [15:0]                   timeout_cnt
);

    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DepthL      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ------------------------------------------------------------------ capture / commit
    logic        pend_v_q, pend_v_d;
    logic [3:0]  pend_op_q, pend_op_d;
    logic [23:0] pend_addr_q, pend_addr_d;
    logic        mac_hit;
    logic        com_v;
    logic [3:0]  com_op;
    logic [23:0] com_addr;
    logic        com_drop, com_good;

    // Staging register between commit and FIFO write; gives the fixed two-cycle issue latency.
    logic        stg_v_q;
    logic [3:0]  stg_op_q;
    logic [23:0] stg_addr_q;

    always_comb begin
        mac_hit     = RxValid && ((dst_mac_reg == MAC) || (dst_mac_reg == 48'hFFFF_FFFF_FFFF));
        com_op      = mac_hit ? opcode : pend_op_q;
        com_addr    = mac_hit ? address : pend_addr_q;
        com_v       = RxEndFrm && (mac_hit || pend_v_q);
        com_drop    = com_v && (CrcError || (com_op == 4'hF));
        com_good    = com_v && !CrcError && (com_op != 4'hF) && (com_op != 4'h0);
        pend_v_d    = pend_v_q;
        pend_op_d   = pend_op_q;
        pend_addr_d = pend_addr_q;
        if (mac_hit) begin
            pend_op_d   = opcode;
            pend_addr_d = address;
            pend_v_d    = 1'b1;
        end
        if (com_v) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            pend_v_q    <= 1'b0;
            pend_op_q   <= 4'd0;
            pend_addr_q <= 24'd0;
            stg_v_q     <= 1'b0;
            stg_op_q    <= 4'd0;
            stg_addr_q  <= 24'd0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_op_q   <= pend_op_d;
            pend_addr_q <= pend_addr_d;
            stg_v_q     <= com_good;
            stg_op_q    <= com_op;
            stg_addr_q  <= com_addr;
        end
    end

    // ------------------------------------------------------------------ FIFO
    logic [27:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d, level_after_pop;
    logic          push, pop, stg_drop;
    logic [27:0]   head;
    state_e        state_q, state_d;

    always_comb begin
        pop             = (state_q == StIdle) && (level_q != '0);
        level_after_pop = level_q - {{AW{1'b0}}, pop};
        push            = stg_v_q && (level_after_pop < DepthL);
        stg_drop        = stg_v_q && !push;
        level_d         = level_after_pop + {{AW{1'b0}}, push};
        head            = mem_q[rd_ptr_q];
    end

    always_ff @(posedge MRxClk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {stg_op_q, stg_addr_q};
        end
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------ issue FSM
    logic        req_q, req_d;
    logic [3:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] timer_q, timer_d;
    logic        done_inc, to_inc;
    logic [15:0] drop_q, done_q, to_q;
    logic [1:0]  drop_inc;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        op_d     = op_q;
        addr_d   = addr_q;
        timer_d  = timer_q;
        done_inc = 1'b0;
        to_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    op_d    = head[27:24];
                    addr_d  = head[23:0];
                    req_d   = 1'b1;
                    timer_d = 16'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Ack in the final timeout cycle still counts as a completion.
                if (cmd_ack) begin
                    req_d    = 1'b0;
                    done_inc = 1'b1;
                    state_d  = StGap;
                end else if (timer_q == TimeoutLast) begin
                    req_d    = 1'b0;
                    to_inc   = 1'b1;
                    state_d  = StGap;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
        drop_inc = {1'b0, com_drop} + {1'b0, stg_drop};
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            op_q    <= 4'd0;
            addr_q  <= 24'd0;
            timer_q <= 16'd0;
            drop_q  <= 16'd0;
            done_q  <= 16'd0;
            to_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            drop_q  <= sat_add(drop_q, drop_inc);
            done_q  <= sat_add(done_q, {1'b0, done_inc});
            to_q    <= sat_add(to_q, {1'b0, to_inc});
        end
    end

    assign cmd_req     = req_q;
    assign cmd_op      = op_q;
    assign cmd_addr    = addr_q;
    assign busy        = (state_q != StIdle) || (level_q != '0);
    assign fifo_level  = level_q;
    assign drop_cnt    = drop_q;
    assign done_cnt    = done_q;
    assign timeout_cnt = to_q;

endmodule

// File: tb/tb_eth_rxcmd_scheduler.sv
// Directed bench for eth_rxcmd_scheduler: a table of single-frame vectors plus hand-written
// sequences for timeout, FIFO overflow and reset during a handshake.
module tb_eth_rxcmd_scheduler;

    localparam logic [47:0] StaMac = 48'h0200_1122_3344;
    localparam logic [47:0] Foreign = 48'h0200_1122_3345;
    localparam logic [47:0] Bcast = 48'hFFFF_FFFF_FFFF;

    logic        MRxClk = 1'b0;
    logic        Reset;
    logic        RxValid, RxEndFrm, CrcError, cmd_ack;
    logic [3:0]  opcode;
    logic [23:0] address;
    logic [47:0] dst_mac_reg;
    logic [47:0] MAC;
    logic        cmd_req, busy;
    logic [3:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt, done_cnt, timeout_cnt;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;
    int exp_done = 0;
    int exp_to = 0;

    eth_rxcmd_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .MRxClk(MRxClk), .Reset(Reset), .RxValid(RxValid), .opcode(opcode), .address(address),
        .dst_mac_reg(dst_mac_reg), .MAC(MAC), .RxEndFrm(RxEndFrm), .CrcError(CrcError),
        .cmd_req(cmd_req), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_ack(cmd_ack),
        .busy(busy), .fifo_level(fifo_level), .drop_cnt(drop_cnt), .done_cnt(done_cnt),
        .timeout_cnt(timeout_cnt)
    );

    always #5 MRxClk = ~MRxClk;

    typedef struct {
        logic [47:0] dst;
        logic [3:0]  op;
        logic [23:0] addr;
        logic        crc;
        logic        same;
        logic        exp_issue;
        int          exp_drop;
        int          exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MRxClk);
        #1;
    endtask

    // Same-cycle capture+commit of one frame; returns just after the commit edge.
    task automatic frame_now(input logic [47:0] dst, input logic [3:0] op, input logic [23:0] a);
        RxValid = 1'b1; RxEndFrm = 1'b1; CrcError = 1'b0;
        dst_mac_reg = dst; opcode = op; address = a;
        tick();
        RxValid = 1'b0; RxEndFrm = 1'b0; opcode = 4'd0; address = 24'd0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (cmd_req !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        if (cmd_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s actual=req_low_after_%0d expected=req_high", name, n);
        end
    endtask

    task automatic ack_once();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        int lows;
        Reset = 1'b1; RxValid = 1'b0; RxEndFrm = 1'b0; CrcError = 1'b0; cmd_ack = 1'b0;
        opcode = 4'd0; address = 24'd0; dst_mac_reg = 48'd0; MAC = StaMac;

        vecs[0] = '{StaMac,  4'h3, 24'h001234, 1'b0, 1'b0, 1'b1, 0, 1};
        vecs[1] = '{Bcast,   4'h5, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1, 1};
        vecs[2] = '{Foreign, 4'h7, 24'h000001, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[3] = '{StaMac,  4'h0, 24'h000002, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[4] = '{StaMac,  4'hF, 24'h000003, 1'b0, 1'b0, 1'b0, 2, 1};
        vecs[5] = '{StaMac,  4'h2, 24'h00BEEF, 1'b0, 1'b1, 1'b1, 2, 2};
        vecs[6] = '{Bcast,   4'hA, 24'h123456, 1'b0, 1'b0, 1'b1, 2, 3};
        vecs[7] = '{Foreign, 4'h9, 24'h777777, 1'b1, 1'b1, 1'b0, 2, 3};

        tick();
        tick();
        chk("rst_req", {47'd0, cmd_req}, 48'd0);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_level", {45'd0, fifo_level}, 48'd0);
        chk("rst_op_addr", {20'd0, cmd_op, cmd_addr}, 48'd0);
        chk("rst_cnts", {drop_cnt, done_cnt, timeout_cnt}, 48'd0);
        Reset = 1'b0;
        tick();

        // Table-driven single frames.
        for (int i = 0; i < 8; i++) begin
            dst_mac_reg = vecs[i].dst;
            opcode = vecs[i].op;
            address = vecs[i].addr;
            RxValid = 1'b1;
            if (vecs[i].same) begin
                RxEndFrm = 1'b1;
                CrcError = vecs[i].crc;
            end else begin
                tick();
                RxValid = 1'b0; opcode = 4'd0; address = 24'd0;
                tick();
                RxEndFrm = 1'b1;
                CrcError = vecs[i].crc;
            end
            tick();
            RxValid = 1'b0; RxEndFrm = 1'b0; CrcError = 1'b0; opcode = 4'd0; address = 24'd0;
            chk($sformatf("v%0d_req_k", i), {47'd0, cmd_req}, 48'd0);
            tick();
            chk($sformatf("v%0d_req_k1", i), {47'd0, cmd_req}, 48'd0);
            tick();
            chk($sformatf("v%0d_issue", i), {47'd0, cmd_req}, {47'd0, vecs[i].exp_issue});
            if (vecs[i].exp_issue) begin
                chk($sformatf("v%0d_op", i), {44'd0, cmd_op}, {44'd0, vecs[i].op});
                chk($sformatf("v%0d_addr", i), {24'd0, cmd_addr}, {24'd0, vecs[i].addr});
                repeat (3) tick();
                chk($sformatf("v%0d_req_hold", i), {47'd0, cmd_req}, 48'd1);
                ack_once();
                chk($sformatf("v%0d_req_drop", i), {47'd0, cmd_req}, 48'd0);
                chk($sformatf("v%0d_op_keep", i), {44'd0, cmd_op}, {44'd0, vecs[i].op});
                tick();
                tick();
            end else begin
                repeat (3) tick();
                chk($sformatf("v%0d_no_req", i), {47'd0, cmd_req}, 48'd0);
            end
            chk($sformatf("v%0d_busy", i), {47'd0, busy}, 48'd0);
            chk($sformatf("v%0d_drop", i), {32'd0, drop_cnt}, 48'(vecs[i].exp_drop));
            chk($sformatf("v%0d_done", i), {32'd0, done_cnt}, 48'(vecs[i].exp_done));
        end
        exp_drop = 2;
        exp_done = 3;

        // Timeout, with a second command queued behind it.
        frame_now(StaMac, 4'h4, 24'h444444);
        tick();
        tick();
        chk("to_req_rise", {47'd0, cmd_req}, 48'd1);
        frame_now(StaMac, 4'h6, 24'h666666);
        cnt = 2;
        while (cmd_req === 1'b1 && cnt < 400) begin
            tick();
            if (cmd_req === 1'b1) cnt++;
        end
        chk("to_req_len", 48'(cnt), 48'd255);
        exp_to = 1;
        chk("to_cnt", {32'd0, timeout_cnt}, 48'(exp_to));
        lows = 0;
        while (cmd_req !== 1'b1 && lows < 20) begin
            lows++;
            tick();
        end
        chk("to_gap_len", 48'(lows), 48'd2);
        chk("to_next_op", {44'd0, cmd_op}, 48'h6);
        chk("to_next_addr", {24'd0, cmd_addr}, 48'h666666);
        ack_once();
        exp_done++;
        tick();
        tick();
        chk("to_done", {32'd0, done_cnt}, 48'(exp_done));

        // Six back-to-back frames with backend stalled: one issued, four queued, one dropped.
        for (int i = 1; i <= 6; i++) begin
            frame_now(StaMac, 4'(i), 24'(i * 16'h0101));
        end
        tick();
        tick();
        exp_drop++;
        chk("ovf_drop", {32'd0, drop_cnt}, 48'(exp_drop));
        chk("ovf_level", {45'd0, fifo_level}, 48'd4);
        chk("ovf_busy", {47'd0, busy}, 48'd1);
        for (int i = 1; i <= 5; i++) begin
            wait_req($sformatf("ovf_wait%0d", i));
            chk($sformatf("ovf_op%0d", i), {44'd0, cmd_op}, 48'(i));
            chk($sformatf("ovf_addr%0d", i), {24'd0, cmd_addr}, 48'(i * 16'h0101));
            ack_once();
            exp_done++;
        end
        tick();
        tick();
        chk("ovf_done", {32'd0, done_cnt}, 48'(exp_done));
        chk("ovf_empty", {45'd0, fifo_level}, 48'd0);
        chk("ovf_timeout_same", {32'd0, timeout_cnt}, 48'(exp_to));

        // Reset mid-handshake with two queued and a capture pending in the slot.
        frame_now(StaMac, 4'h1, 24'h000011);
        frame_now(StaMac, 4'h2, 24'h000022);
        frame_now(StaMac, 4'h3, 24'h000033);
        dst_mac_reg = StaMac; opcode = 4'h9; address = 24'h999999; RxValid = 1'b1;
        tick();
        RxValid = 1'b0; opcode = 4'd0; address = 24'd0;
        chk("rq_req_before", {47'd0, cmd_req}, 48'd1);
        chk("rq_level_before", {45'd0, fifo_level}, 48'd2);
        #2;
        Reset = 1'b1;
        #1;
        chk("rq_req", {47'd0, cmd_req}, 48'd0);
        chk("rq_busy", {47'd0, busy}, 48'd0);
        chk("rq_level", {45'd0, fifo_level}, 48'd0);
        chk("rq_op_addr", {20'd0, cmd_op, cmd_addr}, 48'd0);
        chk("rq_cnts", {drop_cnt, done_cnt, timeout_cnt}, 48'd0);
        tick();
        Reset = 1'b0;
        RxEndFrm = 1'b1;
        tick();
        RxEndFrm = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cmd_req === 1'b1 || busy === 1'b1) cnt++;
        end
        chk("rq_no_residual", 48'(cnt), 48'd0);
        chk("rq_cnts_after", {drop_cnt, done_cnt, timeout_cnt}, 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
